// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Values are double-buffered and swapped in only at
// frame boundaries so a displayed number never tears.
module ssd_scan_driver #(
  parameter int REFRESH_DIV    = 100000,
  parameter bit BLANK_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  blank,
  output logic        frame_done,
  output logic        pending,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        an0,
  output logic        an1,
  output logic        an2,
  output logic        an3
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  // Hex nibble to active-low cathode pattern {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pending_q, pending_d;
  logic          fdone_q, fdone_d;
  logic          live_q, live_d;   // display enabled (after first tick when blanking on reset)
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    nib;

  // Next-state: prescaler, digit index, double buffer and registered outputs.
  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    boundary  = tick && (idx_q == 2'd3);

    presc_d   = tick ? {PW{1'b0}} : presc_q + PW'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    live_d    = live_q | tick;
    fdone_d   = boundary;

    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    // The swap always consumes the buffer as it was before this cycle's load.
    if (boundary && pending_q) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end else begin
      disp_d    = disp_q;
    end
    if (load) begin
      pend_d    = value;
      pending_d = 1'b1;
    end else begin
      pend_d    = pend_q;
    end

    case (idx_q)
      2'd0:    nib = disp_q[3:0];
      2'd1:    nib = disp_q[7:4];
      2'd2:    nib = disp_q[11:8];
      2'd3:    nib = disp_q[15:12];
      default: nib = 4'h0;
    endcase

    // Anode and cathode come from the same cycle, so they never disagree.
    if (!live_q || blank[idx_q]) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex_to_seg(nib);
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= {PW{1'b0}};
      idx_q     <= 2'd0;
      disp_q    <= 16'h0000;
      pend_q    <= 16'h0000;
      pending_q <= 1'b0;
      fdone_q   <= 1'b0;
      live_q    <= ~BLANK_ON_RESET;
      seg_q     <= 7'b1111111;
      an_q      <= 4'b1111;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      fdone_q   <= fdone_d;
      live_q    <= live_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign frame_done         = fdone_q;
  assign pending            = pending_q;
  assign {a, b, c, d, e, f, g} = seg_q;
  assign {an3, an2, an1, an0}  = an_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver with REFRESH_DIV=4, BLANK_ON_RESET=0.
// A time-based model predicts every output each cycle; literal checks pin it.
module tb_ssd_scan_driver;

  localparam int DIV = 4;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank;
  logic        frame_done, pending;
  logic        a, b, c, d, e, f, g;
  logic        an0, an1, an2, an3;

  int errors = 0;
  int checks = 0;
  int sc = 0;
  bit chk_en = 1'b0;

  ssd_scan_driver #(.REFRESH_DIV(DIV), .BLANK_ON_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank(blank),
    .frame_done(frame_done), .pending(pending),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .an0(an0), .an1(an1), .an2(an2), .an3(an3)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_w;
  logic [3:0] an_w;
  assign seg_w = {a, b, c, d, e, f, g};
  assign an_w  = {an3, an2, an1, an0};

  // Model state: cycle count since release plus the double-buffer contents.
  int          m_cyc = 0;
  logic [15:0] m_disp = 16'h0, m_pend = 16'h0;
  bit          m_pending = 1'b0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'hF;
  bit          exp_fd = 1'b0, exp_pending = 1'b0;

  // Behavioural model: slot from cycle arithmetic, swap at each 16-cycle boundary.
  always @(posedge clk or negedge rst) begin
    int  slot;
    bit  bnd;
    if (!rst) begin
      m_cyc = 0; m_disp = 16'h0; m_pend = 16'h0; m_pending = 1'b0;
      exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0; exp_pending = 1'b0;
    end else begin
      slot = (m_cyc / DIV) % 4;
      bnd  = (m_cyc % (4 * DIV)) == (4 * DIV - 1);
      if (blank[slot]) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = 4'hF;
        exp_an[slot] = 1'b0;
        exp_seg = HEX_TAB[m_disp[4*slot +: 4]];
      end
      exp_fd = bnd;
      if (bnd && m_pending) begin
        m_disp    = m_pend;
        m_pending = 1'b0;
      end
      if (load) begin
        m_pend    = value;
        m_pending = 1'b1;
      end
      exp_pending = m_pending;
      m_cyc++;
    end
  end

  // Per-cycle compare of all outputs against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({frame_done, pending, seg_w, an_w} !== {exp_fd, exp_pending, exp_seg, exp_an}) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got fd=%b pend=%b seg=%b an=%b expected fd=%b pend=%b seg=%b an=%b",
                 $time, frame_done, pending, seg_w, an_w, exp_fd, exp_pending, exp_seg, exp_an);
      end
      checks++;
      if ($countones(~an_w) > 1) begin
        errors++;
        $display("FAIL one_anode t=%0t: got an=%b expected at most one low", $time, an_w);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (sc=%0d): got %h expected %h", name, sc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      sc++;
    end
  endtask

  task automatic go_to(input int target);
    if (target > sc) step(target - sc);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = 16'h0; blank = 4'h0;
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    chk("reset_an", {12'h0, an_w}, 16'h000F);
    chk("reset_seg", {9'h0, seg_w}, 16'h007F);
    chk("reset_flags", {14'h0, frame_done, pending}, 16'h0000);
    rst = 1'b1;
    sc  = 0;

    // Free-running scan of 0000.
    step(1);
    chk("first_digit_an", {12'h0, an_w}, 16'h000E);
    chk("first_digit_seg", {9'h0, seg_w}, 16'h0001);
    go_to(5);  chk("rot_an1", {12'h0, an_w}, 16'h000D);
    go_to(16); chk("fd_pulse", {15'h0, frame_done}, 16'h0001);
    go_to(17); chk("fd_low", {15'h0, frame_done}, 16'h0000);
    go_to(32);

    // Single load mid-frame.
    go_to(36); do_load(16'h12AF);
    chk("pend_set", {15'h0, pending}, 16'h0001);
    go_to(47); chk("pend_hold", {15'h0, pending}, 16'h0001);
    go_to(48); chk("pend_clr", {15'h0, pending}, 16'h0000);
    go_to(49); chk("d0_F", {5'h0, seg_w, an_w}, {5'h0, 7'b0111000, 4'b1110});
    go_to(53); chk("d1_A", {5'h0, seg_w, an_w}, {5'h0, 7'b0001000, 4'b1101});
    go_to(57); chk("d2_2", {5'h0, seg_w, an_w}, {5'h0, 7'b0010010, 4'b1011});
    go_to(61); chk("d3_1", {5'h0, seg_w, an_w}, {5'h0, 7'b1001111, 4'b0111});

    // Last load wins.
    go_to(66); do_load(16'h1111);
    go_to(70); do_load(16'h2222);
    go_to(81); chk("lastwin_d0", {9'h0, seg_w}, 16'h0012);
    go_to(89); chk("lastwin_d2", {9'h0, seg_w}, 16'h0012);

    // Load coincident with the boundary.
    go_to(100); do_load(16'h4444);
    go_to(111); do_load(16'h3333);
    chk("coinc_pend", {14'h0, frame_done, pending}, 16'h0003);
    go_to(113); chk("coinc_old", {9'h0, seg_w}, 16'h004C);
    go_to(128); chk("coinc_pend_clr", {15'h0, pending}, 16'h0000);
    go_to(129); chk("coinc_new", {9'h0, seg_w}, 16'h0006);

    // Per-digit blanking.
    go_to(144); blank = 4'b0101;
    go_to(145); chk("blank_d0", {5'h0, seg_w, an_w}, {5'h0, 7'b1111111, 4'b1111});
    go_to(149); chk("blank_d1", {5'h0, seg_w, an_w}, {5'h0, 7'b0000110, 4'b1101});
    go_to(153); chk("blank_d2", {5'h0, seg_w, an_w}, {5'h0, 7'b1111111, 4'b1111});
    go_to(157); chk("blank_d3", {5'h0, seg_w, an_w}, {5'h0, 7'b0000110, 4'b0111});
    go_to(160); chk("blank_fd", {15'h0, frame_done}, 16'h0001);
    blank = 4'b0000;

    // Reset mid-frame with a pending load.
    go_to(164); do_load(16'h5555);
    go_to(170); chk("pre_rst", {11'h0, pending, an_w}, {11'h0, 1'b1, 4'b1011});
    rst = 1'b0;
    #1;
    chk("async_rst", {3'h0, frame_done, pending, seg_w, an_w}, {3'h0, 1'b0, 1'b0, 7'h7F, 4'hF});
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    sc  = 0;
    go_to(1);  chk("post_rst_disp", {5'h0, seg_w, an_w}, {5'h0, 7'b0000001, 4'b1110});
    go_to(20); chk("post_rst_pend", {15'h0, pending}, 16'h0000);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Output-side driver for the 4-digit common-anode seven-segment display. It accepts 16-bit values from the operator/result datapath through a load strobe and time-multiplexes the four hex digits onto the shared cathodes a..g. New values are double-buffered and applied only at frame boundaries, so a displayed number never tears.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2
BLANK_ON_RESET, 1, 1: all anodes off until the first digit tick after reset; 0: digit 0 driven on the first edge after reset

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low (rst=0 resets)
value  input  16  hex value to display; nibble i shown on digit i (an0 = bits 3:0)
load  input  1  capture value into pending buffer this cycle
blank  input  4  per-digit blank, bit i=1 turns digit i off; sampled live
frame_done  output  1  one-cycle pulse when digit 3 slot ends
pending  output  1  1 while a loaded value waits for the frame boundary
a, b, c, d, e, f, g  output  1 each  segment cathodes, active-low
an0, an1, an2, an3  output  1 each  digit anodes, active-low

Behaviour:
- Async reset (rst=0): prescaler=0, idx=0, disp_reg=16'h0000, pend_reg=0, pending=0, frame_done=0, a..g=1, an0..an3=1.
- Prescaler counts 0..REFRESH_DIV-1 and wraps; tick = (prescaler == REFRESH_DIV-1).
- On tick: idx <= idx+1, wrapping 3->0. The tick where idx goes 3->0 is the frame boundary.
- At frame boundary: frame_done=1 for exactly that cycle (registered). If pending=1, disp_reg <= pend_reg and pending <= 0.
- load=1: pend_reg <= value, pending <= 1. A later load before the boundary overwrites pend_reg (last value wins).
- load coincident with boundary: the swap uses the old pend_reg. The new value goes to pend_reg with pending staying 1, and it is applied at the next boundary.
- Outputs are registered with 1-cycle latency from idx/disp_reg/blank. The anode for idx is 0, all others 1. Cathodes show the hex pattern of nibble idx of disp_reg.
- blank[idx]=1: all anodes 1 and a..g = 1111111. Timing is unaffected.
- BLANK_ON_RESET=1: outputs stay all-1 until the first tick after reset. BLANK_ON_RESET=0: outputs begin at the first clk edge after reset release.
- Hex patterns (a b c d e f g, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Reset asserted mid-frame: all state returns to reset values immediately. A pending load is discarded.
- Exactly one anode may be low at any time. No anode is ever low while the cathodes are all-lit from a stale nibble; the anode and cathode registers update in the same cycle.

Test Plan:
- REFRESH_DIV=4, BLANK_ON_RESET=0: release reset and run 32 cycles. Anodes rotate an0→an1→an2→an3 every 4 cycles, cathodes stay 0000001, and frame_done pulses every 16 cycles.
- Pulse load with value=16'h12AF mid-frame: pending=1 until the boundary. The next frame shows an0=F(0111000), an1=A(0001000), an2=2(0010010), an3=1(1001111), and pending returns to 0.
- Load 16'h1111 and then 16'h2222 before the same boundary: the next frame shows all digits as 2 (0010010). 1111 is never displayed.
- Load 16'h3333 exactly on the boundary cycle while pending holds 16'h4444: the next frame shows 4444, the following frame shows 3333, and pending is 1 between them.
- Set blank=4'b0101: the an0 and an2 slots show all anodes 1 and a..g=1111111. The an1 and an3 slots display normally and the frame period is unchanged at 16 cycles.
- Assert rst=0 mid-frame with pending=1: all outputs go to 1 asynchronously (before the next clk edge). After release the display shows 0000 and pending=0.
